// File: rtl/commit_unit.sv
// In-order retirement stage behind the ROB: register writeback, store commit handshake, mispredict flush.
// Optional performance counters are enabled with `define COMMIT_PERF_CNT_EN.
//
// state     | meaning
// RUN       | retire the head when it is done
// ST_WAIT   | store head: hold st_req_o until the store buffer acks
// FLUSH     | one quiet cycle after a mispredict while the ROB reinitialises
module commit_unit #(
    parameter int ROB_IDX_W  = 5,
    parameter int XLEN       = 32,
    parameter int ST_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 head_valid_i,
    input  logic                 head_done_i,
    input  logic [ROB_IDX_W-1:0] head_rob_idx_i,
    input  logic [4:0]           head_rd_addr_i,
    input  logic [XLEN-1:0]      head_rd_data_i,
    input  logic                 head_regf_we_i,
    input  logic                 head_is_store_i,
    input  logic                 head_is_branch_i,
    input  logic                 head_br_en_i,
    input  logic                 head_prediction_i,
    input  logic [XLEN-1:0]      head_pc_new_i,
    output logic                 dequeue_o,
    output logic                 rf_we_o,
    output logic [4:0]           rf_rd_addr_o,
    output logic [XLEN-1:0]      rf_rd_data_o,
    output logic [ROB_IDX_W-1:0] rf_rob_idx_o,
    output logic                 flush_o,
    output logic [XLEN-1:0]      redirect_pc_o,
    output logic                 st_req_o,
    input  logic                 st_ack_i,
    output logic [ROB_IDX_W-1:0] st_rob_idx_o,
    output logic                 st_err_o
`ifdef COMMIT_PERF_CNT_EN
    ,
    output logic [63:0]          perf_retired_o,
    output logic [31:0]          perf_flush_o,
    output logic [31:0]          perf_st_stall_o
`endif
);

    localparam int CNT_W = $clog2(ST_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(ST_TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_ST_WAIT = 2'd1,
        S_FLUSH   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             st_err_q, st_err_d;

    logic ready;
    logic mispredict;

    assign ready      = head_valid_i & head_done_i;
    assign mispredict = head_is_branch_i & (head_br_en_i != head_prediction_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            wait_cnt_q <= '0;
            st_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            st_err_q   <= st_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_RUN: begin
                if (ready) begin
                    if (head_is_store_i) begin
                        state_d    = S_ST_WAIT;
                        wait_cnt_d = '0;
                    end else if (mispredict) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_ST_WAIT: begin
                if (st_ack_i) begin
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != TIMEOUT_C) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_FLUSH: state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
        // The request is never dropped on timeout; the error only flags it.
        st_err_d = st_err_q | ((state_q == S_ST_WAIT) && !st_ack_i && (wait_cnt_d == TIMEOUT_C));
    end

    always_comb begin
        dequeue_o     = 1'b0;
        rf_we_o       = 1'b0;
        rf_rd_addr_o  = '0;
        rf_rd_data_o  = '0;
        rf_rob_idx_o  = '0;
        flush_o       = 1'b0;
        redirect_pc_o = '0;
        st_req_o      = 1'b0;
        st_rob_idx_o  = '0;
        if (!rst) begin
            case (state_q)
                S_RUN: begin
                    if (ready && !head_is_store_i) begin
                        rf_we_o      = head_regf_we_i & (head_rd_addr_i != 5'd0);
                        rf_rd_addr_o = head_rd_addr_i;
                        rf_rd_data_o = head_rd_data_i;
                        rf_rob_idx_o = head_rob_idx_i;
                        // Mispredicted heads are retired by the ROB flush path, not by dequeue.
                        if (mispredict) begin
                            flush_o       = 1'b1;
                            redirect_pc_o = head_pc_new_i;
                        end else begin
                            dequeue_o = 1'b1;
                        end
                    end
                end
                S_ST_WAIT: begin
                    st_req_o     = 1'b1;
                    st_rob_idx_o = head_rob_idx_i;
                    dequeue_o    = st_ack_i;
                end
                default: ;
            endcase
        end
    end

    assign st_err_o = st_err_q & ~rst;

`ifdef COMMIT_PERF_CNT_EN
    logic [63:0] perf_retired_q;
    logic [31:0] perf_flush_q;
    logic [31:0] perf_st_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_retired_q  <= '0;
            perf_flush_q    <= '0;
            perf_st_stall_q <= '0;
        end else begin
            if ((dequeue_o || flush_o) && !(&perf_retired_q))
                perf_retired_q <= perf_retired_q + 64'd1;
            if (flush_o && !(&perf_flush_q))
                perf_flush_q <= perf_flush_q + 32'd1;
            if ((state_q == S_ST_WAIT) && !st_ack_i && !(&perf_st_stall_q))
                perf_st_stall_q <= perf_st_stall_q + 32'd1;
        end
    end

    assign perf_retired_o  = perf_retired_q;
    assign perf_flush_o    = perf_flush_q;
    assign perf_st_stall_o = perf_st_stall_q;
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit: directed scenarios plus randomized heads,
// every cycle compared against a behavioural retirement model.
module tb_commit_unit;

    localparam int ROB_IDX_W  = 5;
    localparam int XLEN       = 32;
    localparam int ST_TIMEOUT = 255;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 head_valid_i, head_done_i;
    logic [ROB_IDX_W-1:0] head_rob_idx_i;
    logic [4:0]           head_rd_addr_i;
    logic [XLEN-1:0]      head_rd_data_i;
    logic                 head_regf_we_i, head_is_store_i, head_is_branch_i;
    logic                 head_br_en_i, head_prediction_i;
    logic [XLEN-1:0]      head_pc_new_i;
    logic                 dequeue_o, rf_we_o;
    logic [4:0]           rf_rd_addr_o;
    logic [XLEN-1:0]      rf_rd_data_o;
    logic [ROB_IDX_W-1:0] rf_rob_idx_o;
    logic                 flush_o;
    logic [XLEN-1:0]      redirect_pc_o;
    logic                 st_req_o, st_ack_i;
    logic [ROB_IDX_W-1:0] st_rob_idx_o;
    logic                 st_err_o;
`ifdef COMMIT_PERF_CNT_EN
    logic [63:0]          perf_retired_o;
    logic [31:0]          perf_flush_o, perf_st_stall_o;
`endif

    commit_unit #(.ROB_IDX_W(ROB_IDX_W), .XLEN(XLEN), .ST_TIMEOUT(ST_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .head_valid_i(head_valid_i), .head_done_i(head_done_i),
        .head_rob_idx_i(head_rob_idx_i), .head_rd_addr_i(head_rd_addr_i),
        .head_rd_data_i(head_rd_data_i), .head_regf_we_i(head_regf_we_i),
        .head_is_store_i(head_is_store_i), .head_is_branch_i(head_is_branch_i),
        .head_br_en_i(head_br_en_i), .head_prediction_i(head_prediction_i),
        .head_pc_new_i(head_pc_new_i),
        .dequeue_o(dequeue_o), .rf_we_o(rf_we_o), .rf_rd_addr_o(rf_rd_addr_o),
        .rf_rd_data_o(rf_rd_data_o), .rf_rob_idx_o(rf_rob_idx_o),
        .flush_o(flush_o), .redirect_pc_o(redirect_pc_o),
        .st_req_o(st_req_o), .st_ack_i(st_ack_i), .st_rob_idx_o(st_rob_idx_o),
        .st_err_o(st_err_o)
`ifdef COMMIT_PERF_CNT_EN
        , .perf_retired_o(perf_retired_o), .perf_flush_o(perf_flush_o),
        .perf_st_stall_o(perf_st_stall_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: whether a store is pending and for how long, whether the
    // previous cycle flushed, and the sticky error.
    bit m_in_store, m_flush_next, m_err;
    int m_wait;

    task automatic model_check();
        logic e_deq, e_we, e_flush, e_req, e_err;
        logic [4:0] e_addr;
        logic [XLEN-1:0] e_data, e_pc;
        logic [ROB_IDX_W-1:0] e_idx, e_stidx;
        e_deq = 0; e_we = 0; e_flush = 0; e_req = 0;
        e_addr = '0; e_data = '0; e_pc = '0; e_idx = '0; e_stidx = '0;
        e_err = rst ? 1'b0 : m_err;
        if (!rst && !m_flush_next) begin
            if (m_in_store) begin
                e_req   = 1;
                e_stidx = head_rob_idx_i;
                e_deq   = st_ack_i;
            end else if (head_valid_i && head_done_i && !head_is_store_i) begin
                e_we   = head_regf_we_i && (head_rd_addr_i != 0);
                e_addr = head_rd_addr_i;
                e_data = head_rd_data_i;
                e_idx  = head_rob_idx_i;
                if (head_is_branch_i && (head_br_en_i != head_prediction_i)) begin
                    e_flush = 1;
                    e_pc    = head_pc_new_i;
                end else begin
                    e_deq = 1;
                end
            end
        end
        check("dequeue", dequeue_o, e_deq);
        check("rf_we", rf_we_o, e_we);
        check("rf_addr", rf_rd_addr_o, e_addr);
        check("rf_data", rf_rd_data_o, e_data);
        check("rf_idx", rf_rob_idx_o, e_idx);
        check("flush", flush_o, e_flush);
        check("redirect", redirect_pc_o, e_pc);
        check("st_req", st_req_o, e_req);
        check("st_idx", st_rob_idx_o, e_stidx);
        check("st_err", st_err_o, e_err);
    endtask

    task automatic model_advance();
        if (rst) begin
            m_in_store = 0; m_flush_next = 0; m_err = 0; m_wait = 0;
        end else if (m_flush_next) begin
            m_flush_next = 0;
        end else if (m_in_store) begin
            if (st_ack_i) begin
                m_in_store = 0; m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait >= ST_TIMEOUT) m_err = 1;
            end
        end else if (head_valid_i && head_done_i) begin
            if (head_is_store_i) begin
                m_in_store = 1; m_wait = 0;
            end else if (head_is_branch_i && (head_br_en_i != head_prediction_i)) begin
                m_flush_next = 1;
            end
        end
    endtask

    task automatic cyc_a();
        @(negedge clk);
        model_check();
    endtask

    task automatic cyc_b();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic set_head(input logic v, input logic d, input logic [4:0] rd,
                            input logic [XLEN-1:0] data, input logic we,
                            input logic st, input logic br);
        head_valid_i = v; head_done_i = d; head_rd_addr_i = rd; head_rd_data_i = data;
        head_regf_we_i = we; head_is_store_i = st; head_is_branch_i = br;
        head_br_en_i = 0; head_prediction_i = 0; head_pc_new_i = '0;
    endtask

    // Store head enters, ack withheld for `hold` wait cycles, then acked.
    task automatic run_store(input int hold, output logic err_at_ack, output logic req_all);
        set_head(1, 1, 5'd0, '0, 0, 1, 0);
        head_rob_idx_i = 5'd9;
        st_ack_i = 0;
        req_all = 1;
        cyc_a(); cyc_b();
        for (int i = 0; i <= hold; i++) begin
            st_ack_i = (i == hold);
            cyc_a();
            req_all = req_all & st_req_o;
            if (i == hold) err_at_ack = st_err_o;
            cyc_b();
        end
        st_ack_i = 0;
        set_head(0, 0, 5'd0, '0, 0, 0, 0);
    endtask

    logic err_s, req_s;

    initial begin
        m_in_store = 0; m_flush_next = 0; m_err = 0; m_wait = 0;
        rst = 1; st_ack_i = 0; head_rob_idx_i = '0;
        set_head(0, 0, 5'd0, '0, 0, 0, 0);
        cyc_a(); check("rst_deq", dequeue_o, 0); check("rst_err", st_err_o, 0); cyc_b();
        cyc_a(); cyc_b();
        rst = 0;

        // ALU retire
        set_head(1, 1, 5'd5, 32'hDEADBEEF, 1, 0, 0); head_rob_idx_i = 5'd3;
        cyc_a();
        check("alu_deq", dequeue_o, 1); check("alu_we", rf_we_o, 1);
        check("alu_addr", rf_rd_addr_o, 5); check("alu_data", rf_rd_data_o, 32'hDEADBEEF);
        cyc_b();

        // x0 write suppressed
        set_head(1, 1, 5'd0, 32'h1234, 1, 0, 0);
        cyc_a(); check("x0_deq", dequeue_o, 1); check("x0_we", rf_we_o, 0); cyc_b();

        // not done: no action
        set_head(1, 0, 5'd7, 32'h55, 1, 0, 0);
        cyc_a(); check("notdone_deq", dequeue_o, 0); cyc_b();

        // Store handshake: ack low 3 wait cycles, then high
        set_head(1, 1, 5'd0, '0, 0, 1, 0); head_rob_idx_i = 5'd17;
        cyc_a(); check("st_run_req", st_req_o, 0); check("st_run_deq", dequeue_o, 0); cyc_b();
        for (int i = 0; i < 4; i++) begin
            st_ack_i = (i == 3);
            cyc_a();
            check("st_req_hold", st_req_o, 1);
            check("st_idx_hold", st_rob_idx_o, 17);
            check("st_deq_ack", dequeue_o, (i == 3));
            cyc_b();
        end
        st_ack_i = 0;
        set_head(1, 1, 5'd2, 32'hA5, 1, 0, 0);
        cyc_a(); check("st_back_run", dequeue_o, 1); check("st_back_req", st_req_o, 0); cyc_b();

        // Mispredicted JAL with link write
        set_head(1, 1, 5'd1, 32'h1004, 1, 0, 1);
        head_br_en_i = 1; head_prediction_i = 0; head_pc_new_i = 32'h60000040;
        cyc_a();
        check("mp_flush", flush_o, 1); check("mp_pc", redirect_pc_o, 32'h60000040);
        check("mp_deq", dequeue_o, 0); check("mp_link_we", rf_we_o, 1);
        cyc_b();
        set_head(1, 1, 5'd4, 32'h77, 1, 0, 0);
        cyc_a(); check("fl_deq", dequeue_o, 0); check("fl_we", rf_we_o, 0); check("fl_flush", flush_o, 0); cyc_b();
        cyc_a(); check("resume_deq", dequeue_o, 1); cyc_b();

        // Correctly predicted branch retires normally
        set_head(1, 1, 5'd0, '0, 0, 0, 1); head_br_en_i = 1; head_prediction_i = 1;
        cyc_a(); check("bp_ok_deq", dequeue_o, 1); check("bp_ok_flush", flush_o, 0); cyc_b();

        // Timeout boundary: one short of the limit, then exactly at it
        run_store(ST_TIMEOUT - 1, err_s, req_s);
        check("tmo_m1_err", err_s, 0); check("tmo_m1_req", req_s, 1);
        run_store(ST_TIMEOUT, err_s, req_s);
        check("tmo_err", err_s, 1); check("tmo_req", req_s, 1);
        cyc_a(); check("tmo_sticky", st_err_o, 1); cyc_b();

        // Reset in the middle of a store wait
        set_head(1, 1, 5'd0, '0, 0, 1, 0);
        cyc_a(); cyc_b();
        cyc_a(); cyc_b();
        cyc_a(); check("pre_rst_req", st_req_o, 1); cyc_b();
        rst = 1;
        cyc_a(); cyc_b();
        rst = 0;
        cyc_a();
        check("rstw_req", st_req_o, 0); check("rstw_deq", dequeue_o, 0); check("rstw_err", st_err_o, 0);
        cyc_b();

        // Randomized heads
        for (int n = 0; n < 4000; n++) begin
            rst               = ($urandom_range(0, 199) == 0);
            head_valid_i      = ($urandom_range(0, 9) < 8);
            head_done_i       = ($urandom_range(0, 9) < 7);
            head_rob_idx_i    = ROB_IDX_W'($urandom);
            head_rd_addr_i    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            head_rd_data_i    = $urandom;
            head_regf_we_i    = $urandom_range(0, 1);
            head_is_store_i   = ($urandom_range(0, 4) == 0);
            head_is_branch_i  = ($urandom_range(0, 9) < 3);
            head_br_en_i      = $urandom_range(0, 1);
            head_prediction_i = $urandom_range(0, 1);
            head_pc_new_i     = $urandom;
            st_ack_i          = ($urandom_range(0, 9) < 3);
            cyc_a(); cyc_b();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/commit_unit.md
Name: commit_unit

Overview:
- In-order retirement stage directly downstream of the reorder buffer.
- Watches the ROB head entry each cycle and retires it once its status is done:
  - writes rd to the architectural register file / RAT;
  - hands stores to the store buffer with a req/ack handshake;
  - raises a one-cycle flush with a redirect PC on a branch mispredict.
- Drives the ROB dequeue input and the flush bit of the CDB bundle.

Parameters:
- ROB_IDX_W, 5, width of the ROB index (32-entry ROB).
- XLEN, 32, data and PC width.
- ST_TIMEOUT, 255, maximum store-ack wait cycles before the sticky error flag is set.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- head_valid_i  in  1  ROB head entry valid
- head_done_i  in  1  ROB head status == done
- head_rob_idx_i  in  ROB_IDX_W  head rd_rob_idx
- head_rd_addr_i  in  5  head destination register
- head_rd_data_i  in  XLEN  head result
- head_regf_we_i  in  1  head writes a register
- head_is_store_i  in  1  head op_type is store
- head_is_branch_i  in  1  head op_type is branch/jump
- head_br_en_i  in  1  resolved taken
- head_prediction_i  in  1  predicted taken
- head_pc_new_i  in  XLEN  resolved target / fallthrough
- dequeue_o  out  1  ROB dequeue_i
- rf_we_o  out  1  regfile write enable
- rf_rd_addr_o  out  5  regfile write address
- rf_rd_data_o  out  XLEN  regfile write data
- rf_rob_idx_o  out  ROB_IDX_W  tag for RAT entry clear on match
- flush_o  out  1  pipeline flush (CDB flush)
- redirect_pc_o  out  XLEN  fetch redirect target
- st_req_o  out  1  store-buffer commit request
- st_ack_i  in  1  store-buffer commit acknowledge
- st_rob_idx_o  out  ROB_IDX_W  tag of the store being committed
- st_err_o  out  1  sticky store timeout error

Behaviour:
- Reset: all outputs 0, FSM state RUN, wait counter 0, st_err_o cleared.
- Retire condition `ready = head_valid_i & head_done_i`. Evaluation is combinational on head inputs; at most one retirement per cycle.
- RUN state:
  - ready & !store & !mispredict:
    - dequeue_o = 1.
    - rf_we_o = head_regf_we_i & (head_rd_addr_i != 0).
    - rf_rd_addr_o, rf_rd_data_o, rf_rob_idx_o = head fields; all commit outputs are combinational, same cycle.
  - ready & head_is_store_i: go to ST_WAIT; no dequeue this cycle.
  - ready & branch & (head_br_en_i != head_prediction_i):
    - flush_o = 1, redirect_pc_o = head_pc_new_i.
    - dequeue_o = 0 (the ROB flush path retires head itself).
    - rd write still performed for JAL/JALR link.
    - Next state FLUSH.
  - Correctly predicted branch retires as a normal instruction.
- ST_WAIT state:
  - st_req_o = 1 and st_rob_idx_o = head_rob_idx_i, held steady until st_ack_i.
  - On st_ack_i: dequeue_o = 1 same cycle, back to RUN. st_ack_i sampled in the same cycle as the first req is legal.
  - Wait counter increments each waiting cycle. When it reaches ST_TIMEOUT, set st_err_o (sticky until rst) and keep waiting; never drop the request.
- FLUSH state:
  - One cycle. All outputs 0, head ignored (ROB is reinitialising). Returns to RUN.
- Boundaries:
  - head_valid_i = 0 or not done: no action, outputs 0.
  - Head with head_regf_we_i = 1 and rd = x0: dequeued with no write.
  - rst mid ST_WAIT: st_req_o drops the next cycle and no dequeue occurs.
  - st_ack_i outside ST_WAIT: ignored.
  - flush_o is never asserted in the same cycle as dequeue_o or st_req_o.

Optional Feature:
- Macro: COMMIT_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_retired_o [63:0], perf_flush_o [31:0] and perf_st_stall_o [31:0].
  - perf_retired_o counts dequeue_o and flush retirements; perf_flush_o counts mispredicts; perf_st_stall_o counts ST_WAIT cycles without ack.
  - All reset to 0, saturating at their maximum value.
- When undefined: the ports and counters are absent and the rest of the behaviour is unchanged.

Test Plan:
- ALU retire: head valid/done, rd = 5, data 0xDEADBEEF, regf_we = 1 -> same cycle dequeue_o = 1, rf_we_o = 1, addr 5, data 0xDEADBEEF.
- x0 write: rd = 0, regf_we = 1, done -> dequeue_o = 1, rf_we_o = 0.
- Store handshake: store head done, st_ack_i held low 3 cycles then high -> st_req_o high 4 cycles, dequeue_o only in the ack cycle, then back to RUN.
- Mispredict: branch done, br_en = 1, prediction = 0, pc_new = 0x60000040 -> flush_o = 1, redirect_pc_o = 0x60000040, dequeue_o = 0; next cycle all outputs 0 even with a ready head; retire resumes the cycle after.
- Store timeout: ack withheld for ST_TIMEOUT cycles -> st_err_o = 1 and stays 1 after ack; st_req_o continuous throughout.
- Reset mid ST_WAIT: rst asserted during the wait -> next cycle st_req_o = 0, dequeue_o = 0, st_err_o = 0, state RUN.
